// File: rtl/spi_seq_pkg.sv
//----------------------------------------------------------------------------
// Module      : spi_seq_pkg
// Description : Shared types and constants for the SPI transfer sequencer.
//               Holds the FSM state encoding, the master/slave transmit
//               pattern tables and the index/error-count widths.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package spi_seq_pkg;

  localparam int ERR_W   = 4;
  localparam int IDX_W   = 3;
  localparam int DATA_W  = 8;
  localparam int NUM_PAT = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GAP   = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  // Element 0 is the leftmost entry, so MASTER_PAT[0] == 8'h10.
  localparam logic [0:NUM_PAT-1][DATA_W-1:0] MASTER_PAT = {
    8'h10, 8'h44, 8'h21, 8'h34, 8'h77, 8'h88, 8'h32, 8'h16
  };

  localparam logic [0:NUM_PAT-1][DATA_W-1:0] SLAVE_PAT = {
    8'h54, 8'h23, 8'h75, 8'h86, 8'h23, 8'h56, 8'h12, 8'h79
  };

  // Error counter increment that sticks at all-ones.
  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_xfer_sequencer_if.sv
//----------------------------------------------------------------------------
// Module      : spi_xfer_sequencer_if
// Description : Platform-side handshake and data bus between the transfer
//               sequencer and the SPI master/slave platform.
//   om_work_en          : transfer request (sequencer -> platform)
//   om_data_bus_master  : byte the master transmits
//   om_data_bus_slave   : byte the slave transmits
//   im_work_end_master  : master transfer-complete flag
//   im_work_end_slave   : slave transfer-complete flag
//   im_data_bus_master  : byte received by the master
//   im_data_bus_slave   : byte received by the slave
//   modport master : sequencer view; modport slave : platform view
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface spi_xfer_sequencer_if
  import spi_seq_pkg::*;
();

  logic              om_work_en;
  logic [DATA_W-1:0] om_data_bus_master;
  logic [DATA_W-1:0] om_data_bus_slave;
  logic              im_work_end_master;
  logic              im_work_end_slave;
  logic [DATA_W-1:0] im_data_bus_master;
  logic [DATA_W-1:0] im_data_bus_slave;

  modport master (
    output om_work_en,
    output om_data_bus_master,
    output om_data_bus_slave,
    input  im_work_end_master,
    input  im_work_end_slave,
    input  im_data_bus_master,
    input  im_data_bus_slave
  );

  modport slave (
    input  om_work_en,
    input  om_data_bus_master,
    input  om_data_bus_slave,
    output im_work_end_master,
    output im_work_end_slave,
    output im_data_bus_master,
    output im_data_bus_slave
  );

endinterface

`default_nettype wire

// File: rtl/spi_seq_pattern_rom.sv
//----------------------------------------------------------------------------
// Module      : spi_seq_pattern_rom
// Description : Combinational transfer-index to (master, slave) byte lookup.
//   idx         : in  IDX_W  transfer index
//   master_byte : out DATA_W byte the master transmits at idx
//   slave_byte  : out DATA_W byte the slave transmits at idx
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module spi_seq_pattern_rom
  import spi_seq_pkg::*;
(
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] master_byte,
  output logic [DATA_W-1:0] slave_byte
);

  assign master_byte = MASTER_PAT[idx];
  assign slave_byte  = SLAVE_PAT[idx];

endmodule

`default_nettype wire

// File: rtl/spi_xfer_sequencer.sv
//----------------------------------------------------------------------------
// Module      : spi_xfer_sequencer
// Description : Launches a fixed sequence of full-duplex byte exchanges on
//               the SPI platform, waits for both end flags of each transfer,
//               cross-checks the received bytes and reports a saturating
//               error count plus a completion pulse.
//   clk          : in  clock, rising edge
//   rst          : in  synchronous active-high reset
//   im_start     : in  start pulse, honoured only when idle
//   bus          : spi_xfer_sequencer_if.master platform handshake/data
//   om_xfer_idx  : out current transfer index
//   om_busy      : out high whenever not idle
//   om_done      : out one-cycle end-of-sequence pulse
//   om_err_cnt   : out mismatch + timeout count, saturates at 15
//   om_timeout   : out sticky abort flag, cleared by the next start
// Configuration : `SPI_SEQ_LOOPBACK_CHECK_EN enables the received-byte
//                 compare; without it only timeouts are counted.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int GAP_CYCLES     = 10,
  parameter int NUM_XFERS      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    im_start,
  spi_xfer_sequencer_if.master    bus,
  output logic [IDX_W-1:0]        om_xfer_idx,
  output logic                    om_busy,
  output logic                    om_done,
  output logic [ERR_W-1:0]        om_err_cnt,
  output logic                    om_timeout
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_GAP   = ST_GAP;
  localparam logic [2:0] S_RUN   = ST_RUN;
  localparam logic [2:0] S_CHECK = ST_CHECK;
  localparam logic [2:0] S_DONE  = ST_DONE;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RUN_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(GAP_CYCLES - 1);
  localparam logic [RUN_W-1:0] c_run_last = RUN_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_XFERS - 1);

  logic [2:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [ERR_W-1:0]  r_err;
  logic              r_timeout;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [RUN_W-1:0]  r_run_cnt;
  logic              r_end_m;
  logic              r_end_s;

  logic [DATA_W-1:0] w_pat_master;
  logic [DATA_W-1:0] w_pat_slave;
  logic              w_both_end;
  logic              w_mismatch;
  logic              w_bus_valid;

  spi_seq_pattern_rom u_rom (
    .idx         (r_idx),
    .master_byte (w_pat_master),
    .slave_byte  (w_pat_slave)
  );

  // Flags seen on an earlier RUN cycle or on this one both count.
  assign w_both_end = (r_end_m | bus.im_work_end_master) &
                      (r_end_s | bus.im_work_end_slave);

`ifdef SPI_SEQ_LOOPBACK_CHECK_EN
  // Loopback: the master receives the slave's byte and vice versa. A transfer
  // with either side wrong counts as a single error.
  assign w_mismatch = (bus.im_data_bus_master != w_pat_slave) ||
                      (bus.im_data_bus_slave  != w_pat_master);
`else
  assign w_mismatch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_err     <= '0;
      r_timeout <= 1'b0;
      r_gap_cnt <= '0;
      r_run_cnt <= '0;
      r_end_m   <= 1'b0;
      r_end_s   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (im_start) begin
            r_idx     <= '0;
            r_err     <= '0;
            r_timeout <= 1'b0;
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end
        end

        S_GAP: begin
          if (r_gap_cnt == c_gap_last) begin
            r_run_cnt <= '0;
            r_end_m   <= 1'b0;
            r_end_s   <= 1'b0;
            r_state   <= S_RUN;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        S_RUN: begin
          r_end_m <= r_end_m | bus.im_work_end_master;
          r_end_s <= r_end_s | bus.im_work_end_slave;
          // A completion on the last allowed cycle wins over the abort.
          if (w_both_end) begin
            r_state <= S_CHECK;
          end else if (r_run_cnt == c_run_last) begin
            r_timeout <= 1'b1;
            r_err     <= err_sat_inc(r_err);
            r_state   <= S_DONE;
          end else begin
            r_run_cnt <= r_run_cnt + 1'b1;
          end
        end

        S_CHECK: begin
          if (w_mismatch) begin
            r_err <= err_sat_inc(r_err);
          end
          if (r_idx == c_idx_last) begin
            r_state <= S_DONE;
          end else begin
            r_idx     <= r_idx + 1'b1;
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Buses carry the pattern from GAP entry through CHECK so they are settled
  // well before and throughout the request window.
  assign w_bus_valid = (r_state == S_GAP) || (r_state == S_RUN) ||
                       (r_state == S_CHECK);

  assign bus.om_work_en         = (r_state == S_RUN);
  assign bus.om_data_bus_master = w_bus_valid ? w_pat_master : '0;
  assign bus.om_data_bus_slave  = w_bus_valid ? w_pat_slave  : '0;

  assign om_xfer_idx = r_idx;
  assign om_busy     = (r_state != S_IDLE);
  assign om_done     = (r_state == S_DONE);
  assign om_err_cnt  = r_err;
  assign om_timeout  = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_spi_xfer_sequencer.sv
//----------------------------------------------------------------------------
// Module      : tb_spi_xfer_sequencer
// Description : Self-checking bench for spi_xfer_sequencer. A loopback
//               platform model answers each request with configurable
//               end-flag lags and optional byte corruption taken from a
//               per-transfer vector table.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_spi_xfer_sequencer;

  localparam int G = 10;
  localparam int T = 64;
  localparam int N = 8;

`ifdef SPI_SEQ_LOOPBACK_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] xfer_idx;
  logic       busy;
  logic       done;
  logic [3:0] err_cnt;
  logic       timeout;

  spi_xfer_sequencer_if bus_if ();

  spi_xfer_sequencer #(
    .GAP_CYCLES     (G),
    .NUM_XFERS      (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .im_start    (start),
    .bus         (bus_if),
    .om_xfer_idx (xfer_idx),
    .om_busy     (busy),
    .om_done     (done),
    .om_err_cnt  (err_cnt),
    .om_timeout  (timeout)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int done_seen = 0;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  typedef struct {
    logic [7:0] exp_m;
    logic [7:0] exp_s;
    int         lag_m;
    int         lag_s;
    logic [7:0] xm;
    logic [7:0] xs;
    bit         poke_start;
  } vec_t;

  vec_t vec [N];
  vec_t cur [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 1);
    chk("err_cleared", {28'd0, err_cnt}, 0);
    chk("timeout_cleared", {31'd0, timeout}, 0);
    chk("idx_restart", {29'd0, xfer_idx}, 0);
  endtask

  task automatic run_xfer(input int i, input vec_t v, input int exp_wait);
    int n;
    int last;
    bit stable;
    n = 0;
    while (bus_if.om_work_en !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("work_en_rise", {31'd0, bus_if.om_work_en}, 1);
    chk("gap_len", n, exp_wait);
    chk("xfer_idx", {29'd0, xfer_idx}, i);
    chk("tx_master", {24'd0, bus_if.om_data_bus_master}, {24'd0, v.exp_m});
    chk("tx_slave", {24'd0, bus_if.om_data_bus_slave}, {24'd0, v.exp_s});
    bus_if.im_data_bus_master = v.exp_s ^ v.xm;
    bus_if.im_data_bus_slave  = v.exp_m ^ v.xs;
    last   = (v.lag_m > v.lag_s) ? v.lag_m : v.lag_s;
    stable = 1'b1;
    for (int c = 1; c <= last; c++) begin
      bus_if.im_work_end_master = (c == v.lag_m);
      bus_if.im_work_end_slave  = (c == v.lag_s);
      start = v.poke_start && (c == 2);
      if (bus_if.om_work_en !== 1'b1 || bus_if.om_data_bus_master !== v.exp_m ||
          bus_if.om_data_bus_slave !== v.exp_s || xfer_idx !== 3'(i))
        stable = 1'b0;
      tick();
    end
    bus_if.im_work_end_master = 1'b0;
    bus_if.im_work_end_slave  = 1'b0;
    start = 1'b0;
    chk("run_stable", {31'd0, stable}, 1);
    chk("work_en_drop", {31'd0, bus_if.om_work_en}, 0);
  endtask

  task automatic finish_seq(input int exp_err);
    int d0;
    d0 = done_seen;
    tick();
    chk("done_pulse", {31'd0, done}, 1);
    chk("err_cnt", {28'd0, err_cnt}, exp_err);
    tick();
    chk("done_low", {31'd0, done}, 0);
    chk("busy_idle", {31'd0, busy}, 0);
    chk("idx_hold", {29'd0, xfer_idx}, N - 1);
    chk("err_hold", {28'd0, err_cnt}, exp_err);
    chk("bus_idle_zero", {24'd0, bus_if.om_data_bus_master}, 0);
    chk("done_count", done_seen - d0, 1);
  endtask

  task automatic run_seq(input int exp_err);
    start_seq();
    for (int i = 0; i < N; i++) run_xfer(i, cur[i], (i == 0) ? G : G + 1);
    finish_seq(exp_err);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_work_en"}, {31'd0, bus_if.om_work_en}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_outs"}, {busy, done, timeout, err_cnt, xfer_idx,
                         bus_if.om_data_bus_master, bus_if.om_data_bus_slave}, 0);
  endtask

  initial begin
    int n;
    int d0;

    vec[0] = '{8'h10, 8'h54, 21, 21, 8'h00, 8'h00, 1'b0};
    vec[1] = '{8'h44, 8'h23, 21, 16, 8'h00, 8'h00, 1'b0};
    vec[2] = '{8'h21, 8'h75, 21, 21, 8'h00, 8'h00, 1'b1};
    vec[3] = '{8'h34, 8'h86, 16, 21, 8'h00, 8'h00, 1'b0};
    vec[4] = '{8'h77, 8'h23,  1,  1, 8'h00, 8'h00, 1'b0};
    vec[5] = '{8'h88, 8'h56,  3, 21, 8'h00, 8'h00, 1'b0};
    vec[6] = '{8'h32, 8'h12, 21, 21, 8'h00, 8'h00, 1'b0};
    vec[7] = '{8'h16, 8'h79, 21, 21, 8'h00, 8'h00, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    bus_if.im_work_end_master = 1'b0;
    bus_if.im_work_end_slave  = 1'b0;
    bus_if.im_data_bus_master = 8'h00;
    bus_if.im_data_bus_slave  = 8'h00;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Clean loopback with mixed end-flag orderings and a start poke mid-RUN.
    cur = vec;
    run_seq(0);

    // No end flags at all: abort after T RUN cycles.
    start_seq();
    n = 0;
    while (bus_if.om_work_en !== 1'b1 && n < 300) begin tick(); n++; end
    chk("to_rise", n, G);
    n = 0;
    while (bus_if.om_work_en === 1'b1 && n < 300) begin tick(); n++; end
    chk("to_run_len", n, T);
    chk("to_done", {31'd0, done}, 1);
    chk("to_flag", {31'd0, timeout}, 1);
    chk("to_err", {28'd0, err_cnt}, 1);
    tick();
    chk("to_idle", {31'd0, busy}, 0);
    chk("to_flag_hold", {31'd0, timeout}, 1);

    // Master receive corrupted on idx 3: 87 instead of 86.
    cur = vec;
    cur[3].xm = 8'h01;
    run_seq(CHK);

    // Every transfer corrupted, two sequences back to back.
    cur = vec;
    for (int i = 0; i < N; i++) cur[i].xs = 8'hFF;
    run_seq(CHK * 8);
    run_seq(CHK * 8);

    // Reset in the RUN phase of idx 5.
    cur = vec;
    start_seq();
    for (int i = 0; i < 5; i++) run_xfer(i, cur[i], (i == 0) ? G : G + 1);
    n = 0;
    while (bus_if.om_work_en !== 1'b1 && n < 300) begin tick(); n++; end
    chk("rst_run_idx", {29'd0, xfer_idx}, 5);
    d0 = done_seen;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_all_zero("mid_rst");
    rst = 1'b0;
    tick();
    tick();
    chk("rst_no_done", done_seen - d0, 0);
    run_seq(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule

`default_nettype wire

// File: doc/spi_xfer_sequencer.md
# spi_xfer_sequencer

Upstream driver for the SPI master/slave platform: on a start pulse it launches a fixed sequence of full-duplex byte exchanges, presenting one master byte and one slave byte per transfer. It raises `om_work_en`, waits for both the master and slave end flags, then checks each side's received byte against the other side's transmitted byte. It reports a saturating error count and a completion pulse. It replaces the free-running stimulus loop with synthesizable, self-checking sequencing.

## Interface
- `GAP_CYCLES`, 10: idle cycles with `om_work_en` low before each transfer; must be ≥1.
- `NUM_XFERS`, 8: transfers per sequence, 1..8.
- `TIMEOUT_CYCLES`, 1024: maximum cycles in RUN before abort.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `im_start` in 1: one-cycle pulse that starts a sequence; ignored unless in IDLE.
- `om_work_en` out 1: transfer request to the platform.
- `im_work_end_master` in 1: master transfer-complete flag.
- `im_work_end_slave` in 1: slave transfer-complete flag.
- `om_data_bus_master` out 8: byte the master transmits.
- `om_data_bus_slave` out 8: byte the slave transmits.
- `im_data_bus_master` in 8: byte received by the master.
- `im_data_bus_slave` in 8: byte received by the slave.
- `om_xfer_idx` out 3: index of the current transfer.
- `om_busy` out 1: high in every state except IDLE.
- `om_done` out 1: one-cycle pulse at the end of a sequence.
- `om_err_cnt` out 4: mismatch and timeout count, saturates at 15.
- `om_timeout` out 1: sticky flag; set on abort, cleared by the next `im_start` or by reset.

## Operation
- FSM states: IDLE → GAP → RUN → CHECK → (GAP | DONE) → IDLE.
- IDLE: `om_work_en`=0. On `im_start`: idx←0, err←0, `om_timeout`←0, gap counter←0, next state GAP.
- GAP: data buses drive the pattern at idx; `om_work_en`=0. After GAP_CYCLES cycles, go to RUN.
- RUN: `om_work_en`=1 and data buses stay stable.
  - `end_m` and `end_s` are sticky latches of the two end flags; both clear on entry to RUN.
  - The flags may arrive in any order or on the same cycle.
  - When `end_m | im_work_end_master` and `end_s | im_work_end_slave` are both true, go to CHECK.
- CHECK: one cycle with `om_work_en`=0.
  - Mismatch if `im_data_bus_master != SLAVE_PAT[idx]` or `im_data_bus_slave != MASTER_PAT[idx]`.
  - Each mismatching transfer adds 1 to err (not 2).
  - If idx==NUM_XFERS-1, go to DONE; else idx++ and go to GAP.
- Timeout: a RUN cycle counter that reaches TIMEOUT_CYCLES sets `om_timeout`, adds 1 to err (saturating), drops `om_work_en`, and goes to DONE.
- DONE: `om_done`=1 for one cycle, then IDLE. `om_err_cnt`, `om_xfer_idx` and `om_timeout` hold until the next start.
- Pattern ROM pairs (master, slave) at idx 0..7: (10,54) (44,23) (21,75) (34,86) (77,23) (88,56) (32,12) (16,79), hex.

## Timing
- Reset values: every output is 0. This includes the data buses (driven 0 in IDLE) and the FSM state, which resets to IDLE.
- `om_work_en` rises exactly GAP_CYCLES+1 cycles after the `im_start` cycle.
- Data buses are valid from the GAP entry through the CHECK cycle, so they are stable whenever `om_work_en`=1.
- CHECK samples the received buses on the cycle after both ends are seen. The platform holds its outputs at least until `om_work_en` falls.
- `om_work_en` is low for at least GAP_CYCLES+1 cycles between transfers.
- Reset asserted mid-sequence returns the block to IDLE on the next edge with `om_work_en`=0. No `om_done` is produced.
- `im_start` during `om_busy` is ignored.

## Configuration
- Macro: `SPI_SEQ_LOOPBACK_CHECK_EN`.
- Defined: compares received bytes in CHECK and counts mismatches as above.
- Undefined: compare logic is removed. CHECK remains one cycle, and `om_err_cnt` counts timeouts only.

## Structure
- Package `spi_seq_pkg` contains:
  - the state enum (IDLE, GAP, RUN, CHECK, DONE);
  - the MASTER_PAT and SLAVE_PAT constant arrays;
  - the ERR_W=4 and IDX_W=3 constants.
- Sub-module `spi_seq_pattern_rom`: combinational idx→(master, slave) lookup over the package constants.

## Test plan
- Loopback model (master receives slave byte, slave receives master byte), end flags 20 cycles after `om_work_en`, `im_start` pulse → 8 transfers in order 10/54 … 16/79, `om_done` once, `om_err_cnt`=0.
- Model corrupts master receive on idx 3 (returns 87 instead of 86) → `om_err_cnt`=1, sequence completes.
- Slave end 5 cycles before master end on one transfer, then both on the same cycle → `om_work_en` drops exactly one cycle after the later flag in each case.
- End flags never asserted, TIMEOUT_CYCLES=64 → `om_timeout`=1, `om_err_cnt`=1, `om_done` pulse, `om_work_en`=0.
- `rst` asserted during RUN of idx 5 → next cycle `om_work_en`=0, `om_busy`=0, all outputs 0; a fresh `im_start` restarts at idx 0.
- Every transfer corrupted over 2 back-to-back sequences (NUM_XFERS=8) → first `om_err_cnt`=8, second restarts at 0 and ends at 8.
